// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, bridged onto a registered synchronous memory port.
// Optional feature macro LSU_SUBWORD_EN: byte addressing, byte/half loads, read-modify-write stores.
module load_store_unit #(
  parameter int REG_SIZE        = 32,
  parameter int ADDRESS_SPACE_W = 64,
  parameter int ADDR_LIMIT      = ADDRESS_SPACE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic [REG_SIZE-1:0] req_addr,
  input  logic [REG_SIZE-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [REG_SIZE-1:0] resp_rdata,
  output logic                resp_err,
  output logic                mem_EN,
  output logic                mem_RW,
  output logic [REG_SIZE-1:0] addr,
  output logic [REG_SIZE-1:0] wdata,
  input  logic [REG_SIZE-1:0] rdata
);

  localparam int LANE_W = $clog2(REG_SIZE / 8);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, MERGE, RESP} state_e;

  state_e              state_q, state_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_rw_q, mem_rw_d;
  logic [REG_SIZE-1:0] addr_q, addr_d;
  logic [REG_SIZE-1:0] wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [REG_SIZE-1:0] resp_rdata_q, resp_rdata_d;
  logic [REG_SIZE-1:0] word_idx;
  logic [REG_SIZE-1:0] load_data;
  logic                misaligned;
  logic                req_bad;

`ifdef LSU_SUBWORD_EN
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [LANE_W-1:0]   off_q, off_d;
  logic [REG_SIZE-1:0] sdata_q, sdata_d;
  logic [LANE_W-1:0]   req_off;
  logic [LANE_W+2:0]   lane_sh;
  logic [REG_SIZE-1:0] lane_mask;
  logic [REG_SIZE-1:0] merged;

  assign req_off  = req_addr[LANE_W-1:0];
  assign word_idx = req_addr >> LANE_W;

  always_comb begin
    unique case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_off[0];
      2'b10:   misaligned = (req_off != '0);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane geometry comes from the request captured at handshake, not the live bus.
  assign lane_sh   = {off_q, 3'b000};
  assign lane_mask = (size_q == 2'b00) ? REG_SIZE'(8'hFF)
                   : (size_q == 2'b01) ? REG_SIZE'(16'hFFFF) : '1;
  assign load_data = (rdata >> lane_sh) & lane_mask;
  assign merged    = (rdata & ~(lane_mask << lane_sh)) | ((sdata_q & lane_mask) << lane_sh);
`else
  logic [1:0] unused_size;

  assign unused_size = req_size;
  assign word_idx    = req_addr;
  assign misaligned  = 1'b0;
  assign load_data   = rdata;
`endif

  assign req_bad = misaligned || (word_idx >= REG_SIZE'(ADDR_LIMIT));

  // NOTE: every _d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    mem_en_d     = 1'b0;
    mem_rw_d     = mem_rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
`ifdef LSU_SUBWORD_EN
    we_d         = we_q;
    size_d       = size_q;
    off_d        = off_q;
    sdata_d      = sdata_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          resp_rdata_d = '0;
          if (req_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ISSUE;
            mem_en_d   = 1'b1;
            addr_d     = word_idx;
            resp_err_d = 1'b0;
`ifdef LSU_SUBWORD_EN
            // Partial stores start with a read; only full-word stores write directly.
            mem_rw_d = req_we && (req_size == 2'b10);
            if (req_we && (req_size == 2'b10)) wdata_d = req_wdata;
            we_d     = req_we;
            size_d   = req_size;
            off_d    = req_off;
            sdata_d  = req_wdata;
`else
            mem_rw_d = req_we;
            if (req_we) wdata_d = req_wdata;
`endif
          end
        end
      end
      ISSUE: begin
        if (mem_rw_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
`ifdef LSU_SUBWORD_EN
          state_d = we_q ? MERGE : CAPTURE;
`else
          state_d = CAPTURE;
`endif
        end
      end
      CAPTURE: begin
        resp_rdata_d = load_data;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      MERGE: begin
`ifdef LSU_SUBWORD_EN
        mem_en_d = 1'b1;
        mem_rw_d = 1'b1;
        wdata_d  = merged;
        state_d  = ISSUE;
`else
        state_d  = IDLE;
`endif
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register is reset, so a reset mid-access leaves no stale pulse or response.
      state_q      <= IDLE;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
`ifdef LSU_SUBWORD_EN
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= '0;
      sdata_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef LSU_SUBWORD_EN
      we_q         <= we_d;
      size_q       <= size_d;
      off_q        <= off_d;
      sdata_q      <= sdata_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_EN     = mem_en_q;
  assign mem_RW     = mem_rw_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;

endmodule
